// File: rtl/rv32i_fetch_unit.sv
// Instruction-fetch stage: own PC, req/ack instruction-memory handshake, prefetch FIFO of
// {pc, inst} pairs towards decode, with stall and redirect (flush + discard of in-flight data).
module rv32i_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         imem_req,
  output logic [XLEN-1:0]              imem_addr,
  input  logic                         imem_ack,
  input  logic [31:0]                  imem_rdata,
  output logic                         dec_valid,
  input  logic                         dec_ready,
  output logic [31:0]                  dec_inst,
  output logic [XLEN-1:0]              dec_pc,
  input  logic                         stall,
  input  logic                         redirect,
  input  logic [XLEN-1:0]              redirect_pc,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH+1);
  localparam int unsigned ResW = CntW + 1;
  localparam logic [ResW-1:0] DepthC = DEPTH[ResW-1:0];

  typedef enum logic [1:0] {StIdle, StReq, StDrop} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] drop_addr_q, drop_addr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [XLEN-1:0] fifo_pc_q   [DEPTH];
  logic [31:0]     fifo_inst_q [DEPTH];

  logic            push, pop, space;
  logic [ResW-1:0] reserved;
  logic [XLEN-1:0] redirect_tgt;
  logic            unused_redirect_lsb;

  assign redirect_tgt        = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign pop  = dec_valid && dec_ready;
  assign push = (state_q == StReq) && imem_ack && !redirect;

  // FIFO bookkeeping; a redirect empties it regardless of same-cycle push/pop.
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (redirect) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // An outstanding request reserves a slot so a response can never find the FIFO full.
  assign reserved = {1'b0, count_d} + ResW'(state_q == StReq);
  assign space    = reserved < DepthC;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    drop_addr_d = drop_addr_q;
    case (state_q)
      StIdle: begin
        if (redirect)            fetch_pc_d = redirect_tgt;
        else if (!stall && space) state_d   = StReq;
      end
      StReq: begin
        if (imem_ack) begin
          if (redirect) begin
            fetch_pc_d = redirect_tgt;
            state_d    = StIdle;
          end else begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
            state_d    = (!stall && space) ? StReq : StIdle;
          end
        end else if (redirect) begin
          // Old request must still complete; keep its address on the bus.
          drop_addr_d = fetch_pc_q;
          fetch_pc_d  = redirect_tgt;
          state_d     = StDrop;
        end
      end
      StDrop: begin
        if (redirect) fetch_pc_d = redirect_tgt;
        if (imem_ack) state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      fetch_pc_q  <= RESET_PC;
      drop_addr_q <= RESET_PC;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      drop_addr_q <= drop_addr_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      fifo_pc_q[wr_ptr_q]   <= fetch_pc_q;
      fifo_inst_q[wr_ptr_q] <= imem_rdata;
    end
  end

  assign imem_req  = (state_q == StReq) || (state_q == StDrop);
  assign imem_addr = (state_q == StDrop) ? drop_addr_q : fetch_pc_q;
  assign dec_valid = (count_q != '0);
  assign dec_inst  = fifo_inst_q[rd_ptr_q];
  assign dec_pc    = fifo_pc_q[rd_ptr_q];
  assign occupancy = count_q;

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Bench for rv32i_fetch_unit: directed scenarios plus random stall/ready/redirect traffic,
// with decode output checked against an architectural program-flow model.
module tb_rv32i_fetch_unit;

  localparam int unsigned     XLEN     = 32;
  localparam int unsigned     DEPTH    = 4;
  localparam logic [XLEN-1:0] RESET_PC = '0;
  localparam int unsigned     OW       = $clog2(DEPTH+1);

  logic            clk = 1'b0;
  logic            rst;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic            dec_valid;
  logic            dec_ready;
  logic [31:0]     dec_inst;
  logic [XLEN-1:0] dec_pc;
  logic            stall;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic [OW-1:0]   occupancy;

  int errors = 0;
  int checks = 0;
  int pops   = 0;

  // Memory responder: 0 = random latency, 1 = immediate ack, 2 = manual ack_man.
  int   ack_mode = 1;
  logic ack_man  = 1'b0;
  int   lat      = 0;
  int   waited   = 0;

  // Architectural stream: restart points queued by stimulus, consumed by the monitor.
  logic [XLEN-1:0] restart_q [$];
  logic [XLEN-1:0] stream_pc;

  rv32i_fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .dec_inst    (dec_inst),
    .dec_pc      (dec_pc),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .occupancy   (occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [XLEN-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  always_comb begin
    imem_ack = 1'b0;
    if (ack_mode == 1)      imem_ack = imem_req;
    else if (ack_mode == 2) imem_ack = ack_man;
    else                    imem_ack = imem_req && (waited >= lat);
  end

  always @(posedge clk) begin
    if (rst || (imem_req && imem_ack)) begin
      waited <= 0;
      lat    <= int'($urandom_range(0, 3));
    end else if (imem_req) begin
      waited <= waited + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect = 1'b0;
    restart_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drive_redirect(input logic [XLEN-1:0] t);
    redirect    = 1'b1;
    redirect_pc = t;
    restart_q.push_back({t[XLEN-1:2], 2'b00});
  endtask

  // Monitor: decode handshakes against the program-flow model, plus bus protocol checks.
  initial begin
    logic            pend;
    logic [XLEN-1:0] pend_addr;
    pend      = 1'b0;
    pend_addr = '0;
    stream_pc = RESET_PC;
    forever begin
      @(negedge clk);
      if (rst) begin
        stream_pc = RESET_PC;
        pend      = 1'b0;
      end else begin
        if (pend) begin
          check("req_held", 64'(imem_req), 64'(1));
          check("addr_stable", 64'(imem_addr), 64'(pend_addr));
        end
        check("valid_vs_occ", 64'(dec_valid), 64'(occupancy != '0));
        check("occ_bound", 64'(occupancy <= DEPTH), 64'(1));
        if (dec_valid && dec_ready) begin
          check("dec_pc", 64'(dec_pc), 64'(stream_pc));
          check("dec_inst", 64'(dec_inst), 64'(mem_word(stream_pc)));
          stream_pc = stream_pc + XLEN'(4);
          pops++;
        end
        if (redirect) begin
          check("restart_avail", 64'(restart_q.size() != 0), 64'(1));
          if (restart_q.size() != 0) stream_pc = restart_q.pop_front();
        end
        pend      = imem_req && !imem_ack;
        pend_addr = imem_addr;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; dec_ready = 1'b1;
    ack_mode = 1; ack_man = 1'b0;

    // Reset release with immediate ack, decode always ready
    do_reset();
    check("rst_req", 64'(imem_req), 64'(0));
    check("rst_valid", 64'(dec_valid), 64'(0));
    check("rst_occ", 64'(occupancy), 64'(0));
    check("rst_addr", 64'(imem_addr), 64'(RESET_PC));
    step();
    check("first_req", 64'(imem_req), 64'(1));
    check("first_addr", 64'(imem_addr), 64'(RESET_PC));
    for (int i = 1; i <= 8; i++) begin
      step();
      check("stream_addr", 64'(imem_addr), 64'(RESET_PC + XLEN'(4 * i)));
      check("occ_le1", 64'(occupancy <= 1), 64'(1));
    end

    // Fill with decode stalled
    dec_ready = 1'b0;
    do_reset();
    repeat (12) step();
    check("fill_occ", 64'(occupancy), 64'(4));
    check("fill_req", 64'(imem_req), 64'(0));
    check("fill_addr", 64'(imem_addr), 64'(32'h10));
    check("fill_head", 64'(dec_pc), 64'(32'h0));
    dec_ready = 1'b1;
    step();
    check("resume_req", 64'(imem_req), 64'(1));
    check("resume_addr", 64'(imem_addr), 64'(32'h10));
    repeat (6) step();

    // Slow ack with redirect in the second wait cycle
    ack_mode = 2; ack_man = 1'b0;
    do_reset();
    step();
    step();
    drive_redirect(32'h100);
    step();
    redirect = 1'b0;
    check("drop_req", 64'(imem_req), 64'(1));
    check("drop_addr", 64'(imem_addr), 64'(32'h0));
    ack_man = 1'b1;
    step();
    ack_man = 1'b0;
    check("drop_done_req", 64'(imem_req), 64'(0));
    step();
    check("redir_req", 64'(imem_req), 64'(1));
    check("redir_addr", 64'(imem_addr), 64'(32'h100));
    ack_mode = 1;
    step();
    check("redir_head_valid", 64'(dec_valid), 64'(1));
    check("redir_head_pc", 64'(dec_pc), 64'(32'h100));
    repeat (4) step();

    // Redirect to unaligned target coincident with ack, two entries queued
    dec_ready = 1'b0; ack_mode = 1;
    do_reset();
    repeat (3) step();
    check("pre_flush_occ", 64'(occupancy), 64'(2));
    drive_redirect(32'h203);
    step();
    redirect = 1'b0;
    check("flush_occ", 64'(occupancy), 64'(0));
    check("flush_valid", 64'(dec_valid), 64'(0));
    step();
    check("flush_req", 64'(imem_req), 64'(1));
    check("flush_addr", 64'(imem_addr), 64'(32'h200));
    dec_ready = 1'b1;
    repeat (5) step();

    // Stall during a pending request acked on its second cycle
    ack_mode = 2; ack_man = 1'b0;
    do_reset();
    step();
    stall = 1'b1;
    step();
    ack_man = 1'b1;
    step();
    ack_man = 1'b0;
    check("stall_req0", 64'(imem_req), 64'(0));
    check("stall_pushed", 64'(dec_valid), 64'(1));
    check("stall_head", 64'(dec_pc), 64'(32'h0));
    step();
    check("stall_req1", 64'(imem_req), 64'(0));
    step();
    check("stall_req2", 64'(imem_req), 64'(0));
    step();
    check("stall_req3", 64'(imem_req), 64'(0));
    stall = 1'b0;
    step();
    check("unstall_req", 64'(imem_req), 64'(1));
    check("unstall_addr", 64'(imem_addr), 64'(32'h4));
    ack_mode = 1;
    repeat (3) step();

    // Reset mid-request with a late ack just after
    ack_mode = 2; ack_man = 1'b0; dec_ready = 1'b0;
    do_reset();
    step();
    ack_man = 1'b1;
    step();
    step();
    ack_man = 1'b0;
    check("prerst_addr", 64'(imem_addr), 64'(32'h8));
    rst = 1'b1;
    restart_q.delete();
    step();
    rst = 1'b0;
    ack_man = 1'b1;
    step();
    ack_man = 1'b0;
    check("late_ack_occ", 64'(occupancy), 64'(0));
    check("late_ack_valid", 64'(dec_valid), 64'(0));
    check("post_rst_addr", 64'(imem_addr), 64'(RESET_PC));
    step();
    check("late_ack_occ2", 64'(occupancy), 64'(0));
    dec_ready = 1'b1;

    // Random traffic
    ack_mode = 0;
    for (int i = 0; i < 2500; i++) begin
      step();
      dec_ready = ($urandom_range(0, 9) < 7);
      stall     = ($urandom_range(0, 9) < 2);
      if ($urandom_range(0, 19) == 0) begin
        if ($urandom_range(0, 3) == 0) drive_redirect(32'hFFFF_FFF0 | XLEN'($urandom_range(0, 15)));
        else                           drive_redirect(XLEN'($urandom));
      end else begin
        redirect = 1'b0;
      end
    end
    step();
    redirect = 1'b0; stall = 1'b0; dec_ready = 1'b1;
    repeat (30) step();
    check("random_progress", 64'(pops > 500), 64'(1));
    check("restart_drained", 64'(restart_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
